// File: rtl/lc4_div_sequencer.sv
// Iterative restoring divider for LC4 DIV/MOD.
// Resolves STEPS quotient bits per CALC cycle; results wait in DONE until taken.
module lc4_div_sequencer #(
   parameter int STEPS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [15:0] i_dividend,
   input  logic [15:0] i_divisor,
   input  logic        i_abort,
   input  logic        i_res_ready,
   output logic        o_ready,
   output logic        o_busy,
   output logic        o_valid,
   output logic [15:0] o_quotient,
   output logic [15:0] o_remainder
);

   localparam int K = 16 / STEPS;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (STEPS != 1 && STEPS != 2 && STEPS != 4) begin : g_bad_steps
      $error("lc4_div_sequencer: STEPS must be 1, 2 or 4");
   end

   logic [1:0]  state;
   logic [15:0] rem;
   logic [15:0] quo;
   logic [15:0] div;
   logic [3:0]  cnt;

   logic [15:0] rem_nx;
   logic [15:0] quo_nx;
   logic [16:0] t;
   logic [16:0] diff;

   // Unrolled restoring steps for one CALC edge
   always_comb begin
      rem_nx = rem;
      quo_nx = quo;
      t      = '0;
      diff   = '0;
      for (int i = 0; i < STEPS; i++) begin
         t      = {rem_nx, quo_nx[15]};
         quo_nx = {quo_nx[14:0], 1'b0};
         diff   = t - {1'b0, div};
         if (t >= {1'b0, div}) begin
            rem_nx    = diff[15:0];
            quo_nx[0] = 1'b1;
         end else begin
            rem_nx = t[15:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         rem   <= '0;
         quo   <= '0;
         div   <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (i_abort) begin
                  state <= S_IDLE;
               end else if (i_start) begin
                  if (i_divisor != 16'd0) begin
                     rem   <= '0;
                     quo   <= i_dividend;
                     div   <= i_divisor;
                     cnt   <= 4'(K - 1);
                     state <= S_CALC;
                  end else begin
                     rem   <= '0;
                     quo   <= '0;
                     state <= S_DONE;
                  end
               end
            end
            S_CALC: begin
               if (i_abort) begin
                  state <= S_IDLE;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  if (cnt == 4'd0) begin
                     state <= S_DONE;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
            end
            S_DONE: begin
               if (i_abort || i_res_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_ready     = (state == S_IDLE);
   assign o_busy      = (state == S_CALC);
   assign o_valid     = (state == S_DONE);
   assign o_quotient  = quo;
   assign o_remainder = rem;

endmodule

// File: tb/tb_lc4_div_sequencer.sv
// Directed and random checks of lc4_div_sequencer.
// Instances with STEPS=1 and STEPS=4 share operand and control inputs.
module tb_lc4_div_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0;
   logic        start4 = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        abort = 1'b0;
   logic        res_ready = 1'b0;

   logic        rdy1, busy1, val1;
   logic [15:0] q1, r1;
   logic        rdy4, busy4, val4;
   logic [15:0] q4, r4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lc4_div_sequencer #(.STEPS(1)) u1 (
      .clk(clk), .rst_n(rst_n), .i_start(start1),
      .i_dividend(dividend), .i_divisor(divisor),
      .i_abort(abort), .i_res_ready(res_ready),
      .o_ready(rdy1), .o_busy(busy1), .o_valid(val1),
      .o_quotient(q1), .o_remainder(r1)
   );

   lc4_div_sequencer #(.STEPS(4)) u4 (
      .clk(clk), .rst_n(rst_n), .i_start(start4),
      .i_dividend(dividend), .i_divisor(divisor),
      .i_abort(abort), .i_res_ready(res_ready),
      .o_ready(rdy4), .o_busy(busy4), .o_valid(val4),
      .o_quotient(q4), .o_remainder(r4)
   );

   // Issue one request; n = edges after accept until o_valid is seen
   task automatic op(input bit sel4, input logic [15:0] a,
                     input logic [15:0] b, output int n,
                     output int nbusy);
      dividend = a;
      divisor  = b;
      if (sel4) start4 = 1'b1;
      else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start4 = 1'b0;
      n = 0;
      nbusy = 0;
      while (((sel4 ? val4 : val1) !== 1'b1) && n < 100) begin
         if ((sel4 ? busy4 : busy1) === 1'b1) nbusy++;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic consume();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if ({rdy1, busy1, val1} !== 3'b100 || q1 !== 16'd0 || r1 !== 16'd0) begin
         fails++;
         $display("FAIL reset_s1: rdy/busy/val=%b q=%h r=%h want 100 0 0",
                  {rdy1, busy1, val1}, q1, r1);
      end
      tests++;
      if ({rdy4, busy4, val4} !== 3'b100 || q4 !== 16'd0 || r4 !== 16'd0) begin
         fails++;
         $display("FAIL reset_s4: rdy/busy/val=%b q=%h r=%h want 100 0 0",
                  {rdy4, busy4, val4}, q4, r4);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int n, nb;
      op(1'b0, 16'd100, 16'd7, n, nb);
      tests++;
      if (n != 16) begin
         fails++;
         $display("FAIL basic_latency: got %0d want 16", n);
      end
      tests++;
      if (nb != 16) begin
         fails++;
         $display("FAIL basic_busy: got %0d want 16", nb);
      end
      tests++;
      if (q1 !== 16'd14 || r1 !== 16'd2) begin
         fails++;
         $display("FAIL basic_result: q=%0d r=%0d want 14 2", q1, r1);
      end
      consume();
      tests++;
      if (rdy1 !== 1'b1 || val1 !== 1'b0) begin
         fails++;
         $display("FAIL basic_consume: rdy=%b val=%b want 1 0", rdy1, val1);
      end
   endtask

   task automatic test_full_width();
      int n, nb;
      op(1'b0, 16'hFFFF, 16'h0001, n, nb);
      tests++;
      if (n != 16 || q1 !== 16'hFFFF || r1 !== 16'h0000) begin
         fails++;
         $display("FAIL full_ffff_1: n=%0d q=%h r=%h want 16 ffff 0000",
                  n, q1, r1);
      end
      consume();
      op(1'b0, 16'h0005, 16'hFFFF, n, nb);
      tests++;
      if (n != 16 || q1 !== 16'h0000 || r1 !== 16'h0005) begin
         fails++;
         $display("FAIL full_5_ffff: n=%0d q=%h r=%h want 16 0000 0005",
                  n, q1, r1);
      end
      consume();
   endtask

   task automatic test_div_zero();
      int n, nb;
      op(1'b0, 16'd1234, 16'd0, n, nb);
      tests++;
      if (n != 0 || nb != 0) begin
         fails++;
         $display("FAIL divzero_latency: n=%0d busy=%0d want 0 0", n, nb);
      end
      tests++;
      if (q1 !== 16'd0 || r1 !== 16'd0) begin
         fails++;
         $display("FAIL divzero_result: q=%h r=%h want 0 0", q1, r1);
      end
      consume();
   endtask

   task automatic test_backpressure();
      int n, nb;
      int bad;
      op(1'b0, 16'd50000, 16'd300, n, nb);
      tests++;
      if (n != 16 || q1 !== 16'd166 || r1 !== 16'd200) begin
         fails++;
         $display("FAIL bp_result: n=%0d q=%0d r=%0d want 16 166 200",
                  n, q1, r1);
      end
      bad = 0;
      dividend = 16'd9;
      divisor  = 16'd2;
      for (int i = 0; i < 10; i++) begin
         start1 = (i == 3);
         if (val1 !== 1'b1 || rdy1 !== 1'b0 || busy1 !== 1'b0 ||
             q1 !== 16'd166 || r1 !== 16'd200) bad++;
         @(negedge clk);
      end
      start1 = 1'b0;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
      end
      consume();
      tests++;
      if (rdy1 !== 1'b1 || val1 !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: rdy=%b val=%b want 1 0", rdy1, val1);
      end
   endtask

   task automatic test_abort();
      int seen;
      abort = 1'b1;
      start1 = 1'b1;
      dividend = 16'd100;
      divisor = 16'd7;
      @(negedge clk);
      start1 = 1'b0;
      abort = 1'b0;
      tests++;
      if (rdy1 !== 1'b1 || busy1 !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle_prio: rdy=%b busy=%b want 1 0",
                  rdy1, busy1);
      end
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (rdy1 !== 1'b1 || busy1 !== 1'b0 || val1 !== 1'b0) begin
         fails++;
         $display("FAIL abort_calc: rdy/busy/val=%b want 100",
                  {rdy1, busy1, val1});
      end
      seen = 0;
      repeat (20) begin
         if (val1 === 1'b1) seen++;
         @(negedge clk);
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL abort_no_valid: %0d valid cycles want 0", seen);
      end
      // abort wins over res_ready in DONE
      dividend = 16'd77;
      divisor = 16'd0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      abort = 1'b1;
      res_ready = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      res_ready = 1'b0;
      tests++;
      if (rdy1 !== 1'b1 || val1 !== 1'b0) begin
         fails++;
         $display("FAIL abort_done: rdy=%b val=%b want 1 0", rdy1, val1);
      end
      dividend = 16'd100;
      divisor = 16'd7;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++;
      if ({rdy1, busy1, val1} !== 3'b100 || q1 !== 16'd0 || r1 !== 16'd0) begin
         fails++;
         $display("FAIL reset_mid_calc: rdy/busy/val=%b q=%h r=%h want 100 0 0",
                  {rdy1, busy1, val1}, q1, r1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (val1 === 1'b1) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL reset_no_valid: %0d valid cycles want 0", seen);
      end
   endtask

   task automatic test_steps4();
      int n, nb;
      op(1'b1, 16'hBEEF, 16'h0013, n, nb);
      tests++;
      if (n != 4 || nb != 4) begin
         fails++;
         $display("FAIL s4_latency: n=%0d busy=%0d want 4 4", n, nb);
      end
      tests++;
      if (q4 !== 16'd2572 || r4 !== 16'd11) begin
         fails++;
         $display("FAIL s4_result: q=%0d r=%0d want 2572 11", q4, r4);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      int n, nb;
      logic [15:0] a, b, eq, er;
      int el;
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if (i % 97 == 5) b = 16'd0;
         else if (i % 7 == 3) b = 16'($urandom_range(1, 15));
         if (b == 16'd0) begin
            eq = 16'd0;
            er = 16'd0;
            el = 0;
         end else begin
            eq = a / b;
            er = a % b;
            el = 4;
         end
         op(1'b1, a, b, n, nb);
         tests++;
         if (n != el) begin
            fails++;
            $display("FAIL rand_latency: %h/%h n=%0d want %0d", a, b, n, el);
         end
         tests++;
         if (q4 !== eq || r4 !== er) begin
            fails++;
            $display("FAIL rand_result: %h/%h q=%h r=%h want %h %h",
                     a, b, q4, r4, eq, er);
         end
         consume();
         tests++;
         if (rdy4 !== 1'b1) begin
            fails++;
            $display("FAIL rand_ready: %h/%h rdy=%b want 1", a, b, rdy4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_width();
      test_div_zero();
      test_backpressure();
      test_abort();
      test_steps4();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
